alu_control_seq: RTL and testbench
==================================

// Module: alu_control_seq
// PURPOSE
//  Registered, parametrised ALU control unit. Decodes ALUOp/funct_ctrl into the ALU function code,
//  adds valid/ready handshakes on both sides, sequences multi-cycle MULTU/DIVU ops with a busy
//  counter, flags illegal encodings, and supports a pipeline flush. Sits between ID and EX.
// PARAMETERS
//  FUNCT_W   6   width of funct_ctrl input and funct output
//  MUL_LAT   4   cycles from MULTU/DIVU accept to out_valid; legal range 2..15
//  CNT_W     4   width of multi-cycle counter; must hold MUL_LAT-1
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  flush       in   1        sync flush: drop held result, abort multi-cycle op
//  in_valid    in   1        alu_op/funct_ctrl valid
//  in_ready    out  1        block can accept this cycle
//  alu_op      in   2        00 load/store, 01 branch, 10 R-type, 11 reserved
//  funct_ctrl  in   FUNCT_W  R-type funct field
//  out_valid   out  1        funct/illegal valid
//  out_ready   in   1        EX consumes result
//  funct       out  FUNCT_W  ALU function code
//  mul_busy    out  1        multi-cycle op in progress
//  illegal     out  1        accepted encoding was illegal (funct=0)
// BEHAVIOUR
//  Reset (async, rst_n=0): funct=0, out_valid=0, illegal=0, mul_busy=0, cnt=0, state=IDLE.
//  Decode: alu_op 00->ADDU 001001; 01->SUBU 001010; 10: funct_ctrl 001011->ADDU,
//   001101->SUBU, 100111->NOR 010011, 101010->SLTU 101010, 011001->MULTU 011001,
//   011011->DIVU 011011; any other 10-case or alu_op 11 -> funct=0, illegal=1.
//  States: IDLE (no result), VALID (result held), MULTI (counting).
//  in_ready = (state==IDLE) | (state==VALID & out_ready); 0 in MULTI. Accept = in_valid & in_ready.
//  Single-cycle op (incl. illegal): accept at edge E -> funct/illegal loaded, out_valid=1, VALID;
//   latency 1 cycle.
//  MULTU/DIVU: accept at E -> funct loaded, illegal=0, mul_busy=1, cnt=MUL_LAT-1, MULTI,
//   out_valid=0. Each edge in MULTI with cnt!=0: cnt--. Edge with cnt==0: out_valid=1,
//   mul_busy=0, VALID. out_valid rises MUL_LAT edges after accept.
//  VALID & !out_ready: funct, illegal, out_valid held stable (no change while stalled).
//  VALID & out_ready & !accept: out_valid=0, IDLE; funct/illegal keep last value.
//  VALID & out_ready & accept (back-to-back): new result replaces old per rules above,
//   out_valid stays 1 for single-cycle op; drops to 0 if new op is multi-cycle.
//  flush=1: next state IDLE, out_valid=0, mul_busy=0, cnt=0, illegal=0; in_ready forced 0 that
//   cycle; flush has priority over accept and counter completion.
//  rst_n low mid-MULTI: immediate abort to reset values; no result emitted.
//  Only decode and output registers clocked; no other internal storage.
// STRUCTURE
//  Package alu_ctrl_pkg: ALU code constants (ADDU/SUBU/NOR/SLTU/MULTU/DIVU), funct_ctrl
//   encodings, ALUOp encodings, state enum {IDLE,VALID,MULTI}.
//  Sub-module alu_funct_decode: combinational alu_op/funct_ctrl -> {funct, illegal, multi}.
//  Top: FSM, counter, output registers, handshake logic.
// TESTING
//  1 Reset release, alu_op=10 funct_ctrl=001011, out_ready=1 -> 1 cycle later out_valid=1,
//    funct=001001, illegal=0; next cycle out_valid=0.
//  2 Back-to-back 001101,100111,101010 with out_ready=1 -> funct 001010,010011,101010 on
//    consecutive cycles, out_valid continuously 1, in_ready always 1.
//  3 MULTU (011001), MUL_LAT=4 -> mul_busy=1 for 4 cycles, in_ready=0, out_valid rises exactly
//    4 edges after accept with funct=011001.
//  4 out_ready=0 for 3 cycles after SUBU result -> funct=001010, out_valid held, in_ready=0;
//    new input accepted on cycle out_ready returns to 1.
//  5 alu_op=11 or funct_ctrl=000000 -> out_valid=1, funct=0, illegal=1.
//  6 DIVU then flush at cycle 2 of count -> out_valid stays 0, mul_busy=0 next cycle; repeat
//    with rst_n pulse mid-count -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU control sequencer: ALU function codes,
// R-type funct_ctrl encodings, ALUOp encodings and the sequencer state enum.
package alu_ctrl_pkg;

    localparam logic [5:0] ALU_ADDU  = 6'b001001;
    localparam logic [5:0] ALU_SUBU  = 6'b001010;
    localparam logic [5:0] ALU_NOR   = 6'b010011;
    localparam logic [5:0] ALU_SLTU  = 6'b101010;
    localparam logic [5:0] ALU_MULTU = 6'b011001;
    localparam logic [5:0] ALU_DIVU  = 6'b011011;

    localparam logic [5:0] FC_ADDU  = 6'b001011;
    localparam logic [5:0] FC_SUBU  = 6'b001101;
    localparam logic [5:0] FC_NOR   = 6'b100111;
    localparam logic [5:0] FC_SLTU  = 6'b101010;
    localparam logic [5:0] FC_MULTU = 6'b011001;
    localparam logic [5:0] FC_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        OP_MEM    = 2'b00,
        OP_BRANCH = 2'b01,
        OP_RTYPE  = 2'b10,
        OP_RSVD   = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        MULTI = 2'd2
    } state_e;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational decode of ALUOp/funct_ctrl into the ALU function code, an illegal
// flag, and a flag marking the multi-cycle operations (MULTU/DIVU).
module alu_funct_decode
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W = 6
) (
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct_ctrl,
    output logic [FUNCT_W-1:0] funct,
    output logic               illegal,
    output logic               multi
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        funct   = '0;
        illegal = 1'b0;
        multi   = 1'b0;
        case (alu_op_e'(alu_op))
            OP_MEM:    funct = FUNCT_W'(ALU_ADDU);
            OP_BRANCH: funct = FUNCT_W'(ALU_SUBU);
            OP_RTYPE: begin
                case (funct_ctrl)
                    FUNCT_W'(FC_ADDU):  funct = FUNCT_W'(ALU_ADDU);
                    FUNCT_W'(FC_SUBU):  funct = FUNCT_W'(ALU_SUBU);
                    FUNCT_W'(FC_NOR):   funct = FUNCT_W'(ALU_NOR);
                    FUNCT_W'(FC_SLTU):  funct = FUNCT_W'(ALU_SLTU);
                    FUNCT_W'(FC_MULTU): begin
                        funct = FUNCT_W'(ALU_MULTU);
                        multi = 1'b1;
                    end
                    FUNCT_W'(FC_DIVU): begin
                        funct = FUNCT_W'(ALU_DIVU);
                        multi = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control unit between ID and EX: decode, valid/ready handshakes on
// both sides, multi-cycle MULTU/DIVU sequencing with a countdown, and pipeline flush.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W = 6,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct_ctrl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FUNCT_W-1:0] funct,
    output logic               mul_busy,
    output logic               illegal
);

    state_e             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [FUNCT_W-1:0] funct_nx, dec_funct;
    logic               illegal_nx, out_valid_nx, mul_busy_nx;
    logic               dec_illegal, dec_multi;
    logic               accept;

    alu_funct_decode #(.FUNCT_W(FUNCT_W)) u_decode (
        .alu_op     (alu_op),
        .funct_ctrl (funct_ctrl),
        .funct      (dec_funct),
        .illegal    (dec_illegal),
        .multi      (dec_multi)
    );

    assign in_ready = !flush && ((state == IDLE) || (state == VALID && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        funct_nx     = funct;
        illegal_nx   = illegal;
        out_valid_nx = out_valid;
        mul_busy_nx  = mul_busy;

        case (state)
            VALID: begin
                if (out_ready) begin
                    out_valid_nx = 1'b0;
                    state_nx     = IDLE;
                end
            end
            MULTI: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    out_valid_nx = 1'b1;
                    mul_busy_nx  = 1'b0;
                    state_nx     = VALID;
                end
            end
            default: ;
        endcase

        // Accept only happens from IDLE or a consumed VALID, so it overrides the drain above.
        if (accept) begin
            funct_nx = dec_funct;
            if (dec_multi) begin
                illegal_nx   = 1'b0;
                mul_busy_nx  = 1'b1;
                cnt_nx       = CNT_W'(MUL_LAT - 1);
                out_valid_nx = 1'b0;
                state_nx     = MULTI;
            end else begin
                illegal_nx   = dec_illegal;
                out_valid_nx = 1'b1;
                state_nx     = VALID;
            end
        end

        // Flush wins over everything, including counter completion; funct keeps its value.
        if (flush) begin
            state_nx     = IDLE;
            cnt_nx       = '0;
            illegal_nx   = 1'b0;
            out_valid_nx = 1'b0;
            mul_busy_nx  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            funct     <= '0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
            mul_busy  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_nx;
            cnt       <= cnt_nx;
            funct     <= funct_nx;
            illegal   <= illegal_nx;
            out_valid <= out_valid_nx;
            mul_busy  <= mul_busy_nx;
        end
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq: stimulus pushes expected results, a monitor
// pops and compares on every output handshake; directed checks cover timing and flush.
module tb_alu_control_seq;

    typedef struct {
        logic [5:0] funct;
        logic       illegal;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] alu_op;
    logic [5:0] funct_ctrl;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] funct;
    logic       mul_busy;
    logic       illegal;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    alu_control_seq #(.FUNCT_W(6), .MUL_LAT(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .funct_ctrl (funct_ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .funct      (funct),
        .mul_busy   (mul_busy),
        .illegal    (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens on the next rising edge whenever out_valid & out_ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_funct", 32'(funct), 32'(e.funct));
                check("sb_illegal", 32'(illegal), 32'(e.illegal));
            end
        end
    end

    // Drive one input for one edge; caller is positioned #1 after a rising edge.
    task automatic send(input logic [1:0] op, input logic [5:0] fc, input bit expect_out,
                        input logic [5:0] ef, input logic ei);
        exp_t e;
        in_valid   = 1'b1;
        alu_op     = op;
        funct_ctrl = fc;
        #1;
        check("in_ready_on_send", 32'(in_ready), 32'd1);
        if (expect_out) begin
            e.funct   = ef;
            e.illegal = ei;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        alu_op     = 2'b00;
        funct_ctrl = 6'b0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_funct", 32'(funct), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_mul_busy", 32'(mul_busy), 32'd0);
        rst_n = 1'b1;

        // 1: single ADDU, one-cycle latency then drain
        send(2'b10, 6'b001011, 1'b1, 6'b001001, 1'b0);
        check("t1_out_valid_hi", 32'(out_valid), 32'd1);
        idle(1);
        check("t1_out_valid_lo", 32'(out_valid), 32'd0);

        // 2: back-to-back SUBU, NOR, SLTU
        send(2'b10, 6'b001101, 1'b1, 6'b001010, 1'b0);
        check("t2_valid_0", 32'(out_valid), 32'd1);
        send(2'b10, 6'b100111, 1'b1, 6'b010011, 1'b0);
        check("t2_valid_1", 32'(out_valid), 32'd1);
        send(2'b10, 6'b101010, 1'b1, 6'b101010, 1'b0);
        check("t2_valid_2", 32'(out_valid), 32'd1);
        idle(1);

        // 3: MULTU, out_valid rises exactly 4 edges after accept
        send(2'b10, 6'b011001, 1'b1, 6'b011001, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t3_mul_busy", 32'(mul_busy), 32'd1);
            check("t3_in_ready", 32'(in_ready), 32'd0);
            check("t3_out_valid_lo", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        check("t3_out_valid_hi", 32'(out_valid), 32'd1);
        check("t3_mul_busy_done", 32'(mul_busy), 32'd0);
        idle(1);

        // 4: SUBU held for 3 stalled cycles, pending ADDU accepted when out_ready returns
        out_ready = 1'b0;
        send(2'b10, 6'b001101, 1'b1, 6'b001010, 1'b0);
        in_valid = 1'b1;
        alu_op   = 2'b00;
        for (int i = 0; i < 3; i++) begin
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_funct", 32'(funct), 32'h0a);
            check("t4_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(2'b00, 6'b000000, 1'b1, 6'b001001, 1'b0);
        check("t4_next_valid", 32'(out_valid), 32'd1);
        idle(1);

        // 5: illegal encodings; branch is legal
        send(2'b11, 6'b001011, 1'b1, 6'b000000, 1'b1);
        check("t5_illegal_rsvd", 32'(illegal), 32'd1);
        send(2'b10, 6'b000000, 1'b1, 6'b000000, 1'b1);
        check("t5_illegal_zero", 32'(illegal), 32'd1);
        send(2'b01, 6'b000000, 1'b1, 6'b001010, 1'b0);
        check("t5_branch_legal", 32'(illegal), 32'd0);
        idle(1);

        // 6a: DIVU aborted by flush in the second count cycle
        send(2'b10, 6'b011011, 1'b0, 6'b0, 1'b0);
        idle(1);
        flush = 1'b1;
        #1;
        check("t6_flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("t6_flush_busy", 32'(mul_busy), 32'd0);
        check("t6_flush_valid", 32'(out_valid), 32'd0);
        check("t6_flush_illegal", 32'(illegal), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("t6_no_result", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end

        // 6b: DIVU aborted by asynchronous reset mid-count
        send(2'b10, 6'b011011, 1'b0, 6'b0, 1'b0);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(mul_busy), 32'd0);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_funct", 32'(funct), 32'd0);
        check("t6_rst_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            check("t6_rst_no_result", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end

        // Recovery after reset
        send(2'b10, 6'b101010, 1'b1, 6'b101010, 1'b0);
        idle(2);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
